bug_eval_sched: RTL and testbench
=================================

BUG_EVAL_SCHED -- requirements
Module: bug_eval_sched

Interface
REQ-001 Parameter: NREQ, 4, number of requesters sharing one bug_eval evaluator.
REQ-002 Parameter: RES_W, 5, evaluator result width.
REQ-003 Parameter: RUN_CYCLES, 10, evaluator run length in cycles after reset release, legal range 1..255.
REQ-004 Parameter: CNT_W, 8, completed-run counter width.
REQ-005 clk  in  1  single clock; all state SHALL update on posedge clk.
REQ-006 rst  in  1  asynchronous, active-high reset.
REQ-007 req_valid  in  NREQ  per-requester run request; held until accepted.
REQ-008 req_ready  out  NREQ  one-hot acceptance; accepted in the cycle where req_valid[i] and req_ready[i] are both high.
REQ-009 eval_rst  out  1  reset to the shared evaluator.
REQ-010 eval_result  in  RES_W  evaluator result.
REQ-011 rsp_valid  out  1  captured result available.
REQ-012 rsp_id  out  clog2(NREQ)  index of the requester that owns the response.
REQ-013 rsp_result  out  RES_W  captured eval_result.
REQ-014 rsp_ready  in  1  response consumed when high with rsp_valid.
REQ-015 busy  out  1  high whenever state is not IDLE.
REQ-016 run_count  out  CNT_W  number of completed response handshakes, wrapping modulo 2^CNT_W.

Function
REQ-017 FSM states SHALL be IDLE, RST, RUN and RESP.
REQ-018 eval_rst SHALL be high in IDLE and RST and low in RUN and RESP.
REQ-019 In IDLE with any req_valid set, the block SHALL assert exactly one req_ready bit, combinationally, for the round-robin winner, then go to RST.
REQ-020 Round-robin search SHALL start at last_grant+1 modulo NREQ; last_grant SHALL update on acceptance.
REQ-021 req_ready SHALL be all-zero outside IDLE; requests raised while busy SHALL wait.
REQ-022 RST SHALL last exactly 1 cycle, then go to RUN with the counter loaded to RUN_CYCLES-1.
REQ-023 RUN SHALL decrement the counter each cycle; at counter 0 it SHALL register eval_result into rsp_result, register the grant index into rsp_id, and go to RESP.
REQ-024 Latency: for acceptance in cycle T, eval_rst SHALL fall at T+2, eval_result SHALL be sampled at the end of T+1+RUN_CYCLES, and rsp_valid SHALL be high from T+2+RUN_CYCLES.
REQ-025 In RESP, rsp_valid, rsp_id and rsp_result SHALL hold stable until rsp_ready is high.
REQ-026 On the response handshake, run_count SHALL increment and the FSM SHALL go to IDLE.
REQ-027 The next acceptance SHALL occur no earlier than the cycle after the handshake.
REQ-028 A req_valid bit dropped before acceptance SHALL be ignored, with no lasting effect.

Reset
REQ-029 While rst is high, the block SHALL hold these values asynchronously: state IDLE, eval_rst 1, req_ready 0, rsp_valid 0, rsp_id 0, rsp_result 0, busy 0, run_count 0, counter 0.
REQ-030 last_grant SHALL reset to NREQ-1, so requester 0 has first priority.
REQ-031 A reset during RST, RUN or RESP SHALL discard the in-flight run with no response.

Structure
REQ-032 bug_eval_pkg SHALL hold the state enum, the RES_W default and the CNT_W default.
REQ-033 Round-robin selection SHALL live in one sub-module, bug_eval_rr_arb (inputs req, last_grant; output one-hot grant).

Verification
REQ-034 Reset release, then req_valid=0001 at T -> req_ready=0001 at T; eval_rst low at T+2; rsp_valid at T+12 with rsp_id=0 and rsp_result equal to eval_result at T+11.
REQ-035 req_valid=1111 held, rsp_ready=1 -> grant order 0,1,2,3,0; run_count=5 after five handshakes.
REQ-036 rsp_ready=0 for 20 cycles in RESP -> rsp_valid, rsp_id and rsp_result stable; req_ready=0000; busy=1.
REQ-037 Accept requester 2, then a new request from requester 1 during RUN -> no req_ready until the cycle after the handshake for requester 2, then req_ready=0010.
REQ-038 rst pulsed mid-RUN -> immediately eval_rst=1, busy=0, rsp_valid=0, run_count=0; no response for the aborted run.
REQ-039 RUN_CYCLES=1, plus run_count rollover check from 255 -> rsp_valid at T+3; run_count wraps 255->0.

Source files
------------

// File: rtl/bug_eval_pkg.sv
// Shared types and defaults for the bug_eval run scheduler and its arbiter.
package bug_eval_pkg;
  localparam int RES_W_DEF = 5;
  localparam int CNT_W_DEF = 8;
  // Run-length counter width; RUN_CYCLES is limited to 1..255.
  localparam int CYC_W     = 8;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_RST,
    ST_RUN,
    ST_RESP
  } state_e;
endpackage

// File: rtl/bug_eval_rr_arb.sv
// Round-robin arbiter: one-hot grant to the first requester after last_grant.
module bug_eval_rr_arb #(
  parameter int NREQ = 4
) (
  input  logic [NREQ-1:0]         req,
  input  logic [$clog2(NREQ)-1:0] last_grant,
  output logic [NREQ-1:0]         grant
);
  logic found;

  // Visit last_grant+1 .. last_grant+NREQ, so last_grant itself is checked last.
  always_comb begin
    grant = '0;
    found = 1'b0;
    for (int i = 1; i <= NREQ; i++) begin
      if (!found && req[(int'(last_grant) + i) % NREQ]) begin
        grant[(int'(last_grant) + i) % NREQ] = 1'b1;
        found = 1'b1;
      end
    end
  end
endmodule

// File: rtl/bug_eval_sched.sv
// Shares one bug_eval evaluator among NREQ requesters: reset it, run RUN_CYCLES
// cycles, capture its result and hold the response until consumed.
module bug_eval_sched
  import bug_eval_pkg::*;
#(
  parameter int NREQ       = 4,
  parameter int RES_W      = RES_W_DEF,
  parameter int RUN_CYCLES = 10,
  parameter int CNT_W      = CNT_W_DEF
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [NREQ-1:0]         req_valid,
  output logic [NREQ-1:0]         req_ready,
  output logic                    eval_rst,
  input  logic [RES_W-1:0]        eval_result,
  output logic                    rsp_valid,
  output logic [$clog2(NREQ)-1:0] rsp_id,
  output logic [RES_W-1:0]        rsp_result,
  input  logic                    rsp_ready,
  output logic                    busy,
  output logic [CNT_W-1:0]        run_count
);
  localparam int IDW = $clog2(NREQ);
  localparam logic [IDW-1:0]   LAST_RST = IDW'(NREQ - 1);
  localparam logic [CYC_W-1:0] CYC_LOAD = CYC_W'(RUN_CYCLES - 1);

  state_e           state_q, state_d;
  logic [CYC_W-1:0] cnt_q, cnt_d;
  logic [IDW-1:0]   last_grant_q, last_grant_d;
  logic             eval_rst_q, eval_rst_d;
  logic             busy_q, busy_d;
  logic             rsp_valid_q, rsp_valid_d;
  logic [IDW-1:0]   rsp_id_q, rsp_id_d;
  logic [RES_W-1:0] rsp_result_q, rsp_result_d;
  logic [CNT_W-1:0] run_count_q, run_count_d;
  logic [NREQ-1:0]  grant;
  logic [IDW-1:0]   grant_idx;

  bug_eval_rr_arb #(.NREQ(NREQ)) u_arb (
    .req        (req_valid),
    .last_grant (last_grant_q),
    .grant      (grant)
  );

  always_comb begin
    grant_idx = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (grant[i]) grant_idx = IDW'(i);
    end
  end

  // Grants are only offered in IDLE; the arbiter output is always a requester that is valid.
  assign req_ready  = (state_q == ST_IDLE && !rst) ? grant : '0;
  assign eval_rst   = eval_rst_q;
  assign busy       = busy_q;
  assign rsp_valid  = rsp_valid_q;
  assign rsp_id     = rsp_id_q;
  assign rsp_result = rsp_result_q;
  assign run_count  = run_count_q;

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    last_grant_d = last_grant_q;
    eval_rst_d   = eval_rst_q;
    busy_d       = busy_q;
    rsp_valid_d  = rsp_valid_q;
    rsp_id_d     = rsp_id_q;
    rsp_result_d = rsp_result_q;
    run_count_d  = run_count_q;
    case (state_q)
      ST_IDLE: begin
        if (|req_valid) begin
          state_d      = ST_RST;
          last_grant_d = grant_idx;
          busy_d       = 1'b1;
        end
      end
      ST_RST: begin
        state_d    = ST_RUN;
        cnt_d      = CYC_LOAD;
        eval_rst_d = 1'b0;
      end
      ST_RUN: begin
        if (cnt_q == '0) begin
          state_d      = ST_RESP;
          rsp_valid_d  = 1'b1;
          rsp_id_d     = last_grant_q;
          rsp_result_d = eval_result;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      ST_RESP: begin
        if (rsp_ready) begin
          state_d     = ST_IDLE;
          rsp_valid_d = 1'b0;
          eval_rst_d  = 1'b1;
          busy_d      = 1'b0;
          run_count_d = run_count_q + 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      cnt_q        <= '0;
      last_grant_q <= LAST_RST;
      eval_rst_q   <= 1'b1;
      busy_q       <= 1'b0;
      rsp_valid_q  <= 1'b0;
      rsp_id_q     <= '0;
      rsp_result_q <= '0;
      run_count_q  <= '0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      last_grant_q <= last_grant_d;
      eval_rst_q   <= eval_rst_d;
      busy_q       <= busy_d;
      rsp_valid_q  <= rsp_valid_d;
      rsp_id_q     <= rsp_id_d;
      rsp_result_q <= rsp_result_d;
      run_count_q  <= run_count_d;
    end
  end
endmodule

// File: tb/tb_bug_eval_sched.sv
// Scoreboard bench for bug_eval_sched: a RUN_CYCLES=10 instance and a RUN_CYCLES=1 instance.
module tb_bug_eval_sched;
  localparam int RUN = 10;

  logic       clk = 1'b0;
  logic       rst, b_rst;
  logic [3:0] req_valid, req_ready, b_req_valid, b_req_ready;
  logic       eval_rst, b_eval_rst, rsp_valid, b_rsp_valid, rsp_ready, b_rsp_ready;
  logic [1:0] rsp_id, b_rsp_id;
  logic [4:0] eval_result, rsp_result, b_rsp_result;
  logic       busy, b_busy;
  logic [7:0] run_count, b_run_count;
  int         cyc = 0;

  typedef struct {
    int         id;
    logic [4:0] res;
    int         due;
  } exp_t;
  exp_t sb[$];
  int   errors = 0;
  int   checks = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [4:0] f(input int c);
    return 5'(c * 7 + 3);
  endfunction

  function automatic int oh2i(input logic [3:0] v);
    for (int i = 0; i < 4; i++) if (v[i]) return i;
    return -1;
  endfunction

  // Evaluator model: result is a known function of the cycle number.
  assign eval_result = f(cyc);

  bug_eval_sched dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready),
    .eval_rst(eval_rst), .eval_result(eval_result), .rsp_valid(rsp_valid),
    .rsp_id(rsp_id), .rsp_result(rsp_result), .rsp_ready(rsp_ready),
    .busy(busy), .run_count(run_count)
  );

  bug_eval_sched #(.RUN_CYCLES(1)) dut_b (
    .clk(clk), .rst(b_rst), .req_valid(b_req_valid), .req_ready(b_req_ready),
    .eval_rst(b_eval_rst), .eval_result(eval_result), .rsp_valid(b_rsp_valid),
    .rsp_id(b_rsp_id), .rsp_result(b_rsp_result), .rsp_ready(b_rsp_ready),
    .busy(b_busy), .run_count(b_run_count)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Raise vld, wait for the grant, push the expected response, step past the acceptance edge.
  task automatic do_accept(input logic [3:0] vld, input bit hold,
                           output logic [3:0] rdy, output int t, output bit ok);
    exp_t e;
    ok = 1'b0; rdy = '0; t = -1;
    req_valid = req_valid | vld;
    for (int i = 0; i < 60; i++) begin
      #2;
      if (|req_ready) begin ok = 1'b1; break; end
      tick();
    end
    if (!ok) return;
    rdy   = req_ready;
    t     = cyc;
    e.id  = oh2i(rdy);
    e.res = f(t + RUN + 1);
    e.due = t + RUN + 2;
    sb.push_back(e);
    tick();
    if (!hold) req_valid = req_valid & ~rdy;
  endtask

  // Wait for rsp_valid and pop the matching expectation; leaves the caller in the response cycle.
  task automatic get_rsp(output exp_t e, output int id, output logic [4:0] res,
                         output int t, output bit ok);
    ok = 1'b0; id = -1; res = '0; t = -1;
    e.id = -1; e.res = '0; e.due = -1;
    for (int i = 0; i < 60; i++) begin
      #2;
      if (rsp_valid) begin ok = 1'b1; break; end
      tick();
    end
    if (!ok || sb.size() == 0) begin ok = 1'b0; return; end
    id  = int'(rsp_id);
    res = rsp_result;
    t   = cyc;
    e   = sb.pop_front();
  endtask

  task automatic test_reset();
    rst = 1'b1; b_rst = 1'b1;
    req_valid = 4'b1111; b_req_valid = '0; rsp_ready = 1'b0; b_rsp_ready = 1'b0;
    repeat (3) tick();
    #1;
    checks++; if (req_ready !== 4'b0000) begin errors++; $display("FAIL rst_req_ready got %b exp 0000", req_ready); end
    checks++; if (eval_rst !== 1'b1) begin errors++; $display("FAIL rst_eval_rst got %b exp 1", eval_rst); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rst_busy got %b exp 0", busy); end
    checks++; if (rsp_valid !== 1'b0) begin errors++; $display("FAIL rst_rsp_valid got %b exp 0", rsp_valid); end
    checks++; if (rsp_id !== 2'd0 || rsp_result !== 5'd0) begin errors++; $display("FAIL rst_rsp_data got %0d/%0d exp 0/0", rsp_id, rsp_result); end
    checks++; if (run_count !== 8'd0) begin errors++; $display("FAIL rst_run_count got %0d exp 0", run_count); end
    rst = 1'b0; b_rst = 1'b0; req_valid = '0;
    tick();
  endtask

  task automatic test_single();
    logic [3:0] rdy; logic [4:0] res; int t, t2, id; bit ok; exp_t e;
    rsp_ready = 1'b1;
    do_accept(4'b0001, 1'b0, rdy, t, ok);
    checks++; if (!ok || rdy !== 4'b0001) begin errors++; $display("FAIL single_grant got %b exp 0001", rdy); end
    #1;
    checks++; if (eval_rst !== 1'b1 || busy !== 1'b1) begin errors++; $display("FAIL single_rst_phase got eval_rst=%b busy=%b exp 1/1", eval_rst, busy); end
    tick(); #1;
    checks++; if (eval_rst !== 1'b0) begin errors++; $display("FAIL single_eval_rst_fall got %b exp 0 at T+2", eval_rst); end
    get_rsp(e, id, res, t2, ok);
    checks++; if (!ok || t2 !== t + 12) begin errors++; $display("FAIL single_latency got cycle %0d exp %0d", t2, t + 12); end
    checks++; if (id !== 0 || res !== e.res) begin errors++; $display("FAIL single_rsp got id=%0d res=%0d exp id=0 res=%0d", id, res, e.res); end
    tick();
    checks++; if (run_count !== 8'd1) begin errors++; $display("FAIL single_run_count got %0d exp 1", run_count); end
  endtask

  task automatic test_round_robin();
    logic [3:0] rdy, exp_rdy; logic [4:0] res; int t, t2, id; bit ok; exp_t e;
    rst = 1'b1; tick(); rst = 1'b0; tick();
    rsp_ready = 1'b1;
    for (int k = 0; k < 5; k++) begin
      exp_rdy = 4'b0001 << (k % 4);
      do_accept(4'b1111, 1'b1, rdy, t, ok);
      checks++; if (!ok || rdy !== exp_rdy) begin errors++; $display("FAIL rr_grant%0d got %b exp %b", k, rdy, exp_rdy); end
      get_rsp(e, id, res, t2, ok);
      checks++; if (!ok || id !== e.id || res !== e.res || t2 !== e.due) begin
        errors++; $display("FAIL rr_rsp%0d got id=%0d res=%0d cyc=%0d exp id=%0d res=%0d cyc=%0d", k, id, res, t2, e.id, e.res, e.due);
      end
      tick();
      if (k == 4) req_valid = '0;
    end
    checks++; if (run_count !== 8'd5) begin errors++; $display("FAIL rr_run_count got %0d exp 5", run_count); end
  endtask

  task automatic test_resp_hold();
    logic [3:0] rdy; logic [4:0] res; int t, t2, id, h; bit ok; exp_t e;
    rsp_ready = 1'b0;
    do_accept(4'b1000, 1'b0, rdy, t, ok);
    checks++; if (!ok || rdy !== 4'b1000) begin errors++; $display("FAIL hold_grant got %b exp 1000", rdy); end
    get_rsp(e, id, res, t2, ok);
    checks++; if (!ok || id !== 3 || res !== e.res || t2 !== e.due) begin errors++; $display("FAIL hold_rsp got id=%0d res=%0d exp id=3 res=%0d", id, res, e.res); end
    req_valid = 4'b0011;
    for (int i = 0; i < 20; i++) begin
      tick(); #1;
      checks++;
      if (rsp_valid !== 1'b1 || rsp_id !== 2'd3 || rsp_result !== e.res || req_ready !== 4'b0000 || busy !== 1'b1) begin
        errors++; $display("FAIL hold_stable%0d got v=%b id=%0d res=%0d rdy=%b busy=%b exp 1/3/%0d/0000/1",
                           i, rsp_valid, rsp_id, rsp_result, req_ready, busy, e.res);
      end
    end
    rsp_ready = 1'b1;
    h = cyc;
    tick();
    do_accept(4'b0000, 1'b0, rdy, t, ok);
    checks++; if (!ok || rdy !== 4'b0001 || t !== h + 1) begin errors++; $display("FAIL hold_next_grant got %b at %0d exp 0001 at %0d", rdy, t, h + 1); end
    get_rsp(e, id, res, t2, ok);
    checks++; if (!ok || id !== 0 || res !== e.res) begin errors++; $display("FAIL hold_next_rsp got id=%0d res=%0d exp 0/%0d", id, res, e.res); end
    tick();
    do_accept(4'b0000, 1'b0, rdy, t, ok);
    checks++; if (!ok || rdy !== 4'b0010) begin errors++; $display("FAIL hold_third_grant got %b exp 0010", rdy); end
    get_rsp(e, id, res, t2, ok);
    checks++; if (!ok || id !== 1 || res !== e.res) begin errors++; $display("FAIL hold_third_rsp got id=%0d res=%0d exp 1/%0d", id, res, e.res); end
    tick();
  endtask

  task automatic test_back_to_back();
    logic [3:0] rdy; logic [4:0] res; int t, t2, id, h; bit ok, bad, seen; exp_t e;
    rsp_ready = 1'b1;
    do_accept(4'b0100, 1'b0, rdy, t, ok);
    checks++; if (!ok || rdy !== 4'b0100) begin errors++; $display("FAIL b2b_grant got %b exp 0100", rdy); end
    repeat (3) tick();
    req_valid[1] = 1'b1;
    bad = 1'b0; seen = 1'b0;
    for (int i = 0; i < 30; i++) begin
      #2;
      if (rsp_valid) begin seen = 1'b1; break; end
      if (req_ready !== 4'b0000) bad = 1'b1;
      tick();
    end
    checks++; if (!seen || bad) begin errors++; $display("FAIL b2b_busy_ready got seen=%b bad=%b exp 1/0", seen, bad); end
    get_rsp(e, id, res, t2, ok);
    checks++; if (!ok || id !== 2 || res !== e.res || req_ready !== 4'b0000) begin
      errors++; $display("FAIL b2b_rsp got id=%0d res=%0d rdy=%b exp 2/%0d/0000", id, res, req_ready, e.res);
    end
    h = t2;
    tick();
    do_accept(4'b0000, 1'b0, rdy, t, ok);
    checks++; if (!ok || rdy !== 4'b0010 || t !== h + 1) begin errors++; $display("FAIL b2b_next got %b at %0d exp 0010 at %0d", rdy, t, h + 1); end
    get_rsp(e, id, res, t2, ok);
    checks++; if (!ok || id !== 1 || res !== e.res) begin errors++; $display("FAIL b2b_next_rsp got id=%0d res=%0d exp 1/%0d", id, res, e.res); end
    tick();
  endtask

  task automatic test_reset_mid_run();
    logic [3:0] rdy; int t; bit ok, bad; exp_t e;
    rsp_ready = 1'b1;
    do_accept(4'b0001, 1'b0, rdy, t, ok);
    checks++; if (!ok || rdy !== 4'b0001) begin errors++; $display("FAIL abort_grant got %b exp 0001", rdy); end
    repeat (4) tick();
    rst = 1'b1;
    #1;
    checks++; if (eval_rst !== 1'b1 || busy !== 1'b0 || rsp_valid !== 1'b0 || run_count !== 8'd0 || req_ready !== 4'b0000) begin
      errors++; $display("FAIL abort_state got eval_rst=%b busy=%b v=%b cnt=%0d rdy=%b exp 1/0/0/0/0000",
                         eval_rst, busy, rsp_valid, run_count, req_ready);
    end
    if (sb.size() > 0) e = sb.pop_back();
    tick();
    rst = 1'b0;
    bad = 1'b0;
    for (int i = 0; i < 20; i++) begin
      tick(); #1;
      if (rsp_valid !== 1'b0 || busy !== 1'b0) bad = 1'b1;
    end
    checks++; if (bad) begin errors++; $display("FAIL abort_no_rsp got a response or busy after reset exp none"); end
  endtask

  task automatic test_short_run_rollover();
    int t, t2; bit ok; exp_t e;
    b_rsp_ready = 1'b1;
    b_req_valid = 4'b0001;
    ok = 1'b0; t = -1;
    for (int i = 0; i < 20; i++) begin
      #2;
      if (|b_req_ready) begin ok = 1'b1; t = cyc; break; end
      tick();
    end
    e.id = 0; e.res = f(t + 2); e.due = t + 3;
    sb.push_back(e);
    checks++; if (!ok || b_req_ready !== 4'b0001) begin errors++; $display("FAIL short_grant got %b exp 0001", b_req_ready); end
    tick();
    b_req_valid = '0;
    ok = 1'b0; t2 = -1;
    for (int i = 0; i < 20; i++) begin
      #2;
      if (b_rsp_valid) begin ok = 1'b1; t2 = cyc; break; end
      tick();
    end
    if (sb.size() > 0) e = sb.pop_front();
    checks++; if (!ok || t2 !== t + 3) begin errors++; $display("FAIL short_latency got cycle %0d exp %0d", t2, t + 3); end
    checks++; if (b_rsp_id !== 2'(e.id) || b_rsp_result !== e.res) begin errors++; $display("FAIL short_rsp got %0d/%0d exp %0d/%0d", b_rsp_id, b_rsp_result, e.id, e.res); end
    tick();
    checks++; if (b_run_count !== 8'd1) begin errors++; $display("FAIL short_run_count got %0d exp 1", b_run_count); end
    b_req_valid = 4'b1111;
    ok = 1'b0;
    for (int i = 0; i < 3000; i++) begin
      #2;
      if (b_run_count == 8'd255) begin ok = 1'b1; break; end
      tick();
    end
    checks++; if (!ok) begin errors++; $display("FAIL wrap_reach255 got %0d exp 255", b_run_count); end
    ok = 1'b0;
    for (int i = 0; i < 20; i++) begin
      #2;
      if (b_rsp_valid) begin ok = 1'b1; break; end
      tick();
    end
    b_req_valid = '0;
    tick(); #1;
    checks++; if (!ok || b_run_count !== 8'd0) begin errors++; $display("FAIL wrap_rollover got %0d exp 0", b_run_count); end
  endtask

  initial begin
    rst = 1'b1; b_rst = 1'b1;
    test_reset();
    test_single();
    test_round_robin();
    test_resp_hold();
    test_back_to_back();
    test_reset_mid_run();
    test_short_run_rollover();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog simulation did not finish in time");
    $fatal(1, "watchdog");
  end
endmodule
